// File: rtl/demux_8_frame_loader.sv
// rtl/demux_8_frame_loader.sv - 8-slot nibble frame loader with shadow bank and atomic commit
//
// Purpose:
//   Loads a stream of W-bit values into an 8-entry shadow bank. A one-cycle COPY then
//   transfers the whole shadow bank to the registered live outputs A..H at once, so a
//   downstream scanner never sees a half-updated frame. Slot index 0..7 maps to A..H.
//
// Ports:
//   clk        - system clock, rising edge
//   rst        - synchronous reset, active-high
//   din        - value to write
//   din_valid  - din/wr_sel/addr_mode are valid this cycle
//   din_ready  - loader accepts a write this cycle (low only during COPY)
//   addr_mode  - 0: sequential via wr_ptr, 1: addressed via wr_sel
//   wr_sel     - target slot when addr_mode=1
//   commit     - request a shadow->live copy
//   a..h       - live slot outputs, registered
//   wr_ptr     - next sequential slot index
//   frame_done - one-cycle pulse after the live bank was updated

module demux_8_frame_loader #(
  parameter int             W    = 4,
  parameter logic [W-1:0]   INIT = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  input  logic         addr_mode,
  input  logic [2:0]   wr_sel,
  input  logic         commit,
  output logic [W-1:0] A,
  output logic [W-1:0] B,
  output logic [W-1:0] C,
  output logic [W-1:0] D,
  output logic [W-1:0] E,
  output logic [W-1:0] F,
  output logic [W-1:0] G,
  output logic [W-1:0] H,
  output logic [2:0]   wr_ptr,
  output logic         frame_done
);

  typedef enum logic {FILL, COPY} state_t;

  state_t       state;
  state_t       state_nxt;
  logic [W-1:0] shadow [8];
  logic         accept;
  logic         seq_write;
  logic         seq_last;
  logic [2:0]   slot;

  assign accept    = din_valid & din_ready;
  assign seq_write = accept & ~addr_mode;
  // A sequential write into slot 7 completes a frame and triggers a copy by itself.
  assign seq_last  = seq_write & (wr_ptr == 3'd7);
  assign slot      = addr_mode ? wr_sel : wr_ptr;

  always_comb begin
    state_nxt = state;
    din_ready = 1'b0;
    case (state)
      FILL: begin
        din_ready = 1'b1;
        // commit and a slot-7 write in the same cycle still give a single COPY
        if (commit || seq_last) begin
          state_nxt = COPY;
        end
      end
      COPY: begin
        state_nxt = FILL;
      end
      default: begin
        state_nxt = FILL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FILL;
      wr_ptr     <= 3'd0;
      frame_done <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        shadow[i] <= INIT;
      end
      A <= INIT;
      B <= INIT;
      C <= INIT;
      D <= INIT;
      E <= INIT;
      F <= INIT;
      G <= INIT;
      H <= INIT;
    end else begin
      state      <= state_nxt;
      frame_done <= (state == COPY);
      // The write lands in shadow at the triggering edge, so the following COPY edge includes it.
      if (accept) begin
        shadow[slot] <= din;
      end
      if (seq_write) begin
        wr_ptr <= wr_ptr + 3'd1;
      end
      if (state == COPY) begin
        A <= shadow[0];
        B <= shadow[1];
        C <= shadow[2];
        D <= shadow[3];
        E <= shadow[4];
        F <= shadow[5];
        G <= shadow[6];
        H <= shadow[7];
      end
    end
  end

endmodule

// File: tb/tb_demux_8_frame_loader.sv
// tb/tb_demux_8_frame_loader.sv - directed scoreboard bench for demux_8_frame_loader

module tb_demux_8_frame_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] din = '0;
  logic       din_valid = 1'b0;
  logic       din_ready;
  logic       addr_mode = 1'b0;
  logic [2:0] wr_sel = '0;
  logic       commit = 1'b0;
  logic [3:0] A, B, C, D, E, F, G, H;
  logic [2:0] wr_ptr;
  logic       frame_done;

  int checks = 0;
  int errors = 0;

  logic [3:0]  m_sh [8];
  logic [31:0] m_live;
  logic [2:0]  m_ptr;
  logic        m_copy;
  logic [31:0] sb [$];

  always #5 clk = ~clk;

  demux_8_frame_loader #(.W(4), .INIT(4'h0)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .addr_mode(addr_mode), .wr_sel(wr_sel), .commit(commit),
    .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G), .H(H),
    .wr_ptr(wr_ptr), .frame_done(frame_done)
  );

  function automatic logic [31:0] live();
    return {A, B, C, D, E, F, G, H};
  endfunction

  function automatic logic [31:0] pk();
    return {m_sh[0], m_sh[1], m_sh[2], m_sh[3], m_sh[4], m_sh[5], m_sh[6], m_sh[7]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_sh[i] = 4'h0;
    m_live = '0;
    m_ptr  = '0;
    m_copy = 1'b0;
    sb.delete();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; din_valid = 1'b0; commit = 1'b0; addr_mode = 1'b0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("rst_live", live(), 32'h0);
    check("rst_wr_ptr", wr_ptr, 0);
    check("rst_din_ready", din_ready, 1);
    check("rst_frame_done", frame_done, 0);
  endtask

  // One clock cycle: drive at negedge, predict, step one edge, compare at next negedge.
  task automatic cyc(input logic v, input logic m, input logic [2:0] s,
                     input logic [3:0] d, input logic c);
    logic trig;
    logic fd_exp;
    logic [31:0] exp_frame;
    din_valid = v; addr_mode = m; wr_sel = s; din = d; commit = c;
    #1;
    check("din_ready", din_ready, !m_copy);
    fd_exp = m_copy;
    if (m_copy) begin
      m_live = pk();
      m_copy = 1'b0;
    end else begin
      trig = c;
      if (v) begin
        if (m) begin
          m_sh[s] = d;
        end else begin
          m_sh[m_ptr] = d;
          if (m_ptr == 3'd7) trig = 1'b1;
          m_ptr = m_ptr + 3'd1;
        end
      end
      if (trig) begin
        m_copy = 1'b1;
        sb.push_back(pk());
      end
    end
    @(posedge clk);
    @(negedge clk);
    check("frame_done", frame_done, fd_exp);
    if (frame_done) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_frame", 1, 0);
      end else begin
        exp_frame = sb.pop_front();
        check("sb_frame", live(), exp_frame);
      end
    end
    check("live", live(), m_live);
    check("wr_ptr", wr_ptr, m_ptr);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 3'd0, 4'h0, 1'b0);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    // 1: reset
    do_reset(2);

    // 2: sequential frame 7..0
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, 3'd0, 4'(7 - i), 1'b0);
      check("seq_hold", live(), 32'h0);
    end
    idle();
    check("seq_frame", live(), 32'h76543210);
    check("seq_wr_ptr", wr_ptr, 0);
    idle();
    check("seq_fd_low", frame_done, 0);

    // 3: addressed write then commit
    cyc(1'b1, 1'b1, 3'd5, 4'h9, 1'b0);
    cyc(1'b0, 1'b0, 3'd0, 4'h0, 1'b1);
    idle();
    check("addr_frame", live(), 32'h76543910);
    check("addr_wr_ptr", wr_ptr, 0);

    // 4: addressed write and commit in the same cycle
    cyc(1'b1, 1'b1, 3'd2, 4'hA, 1'b1);
    idle();
    check("same_cycle_frame", live(), 32'h76A43910);
    idle();
    check("same_cycle_single_fd", frame_done, 0);

    // commit in COPY is ignored; commit together with slot-7 write gives one COPY
    cyc(1'b0, 1'b0, 3'd0, 4'h0, 1'b1);
    cyc(1'b0, 1'b0, 3'd0, 4'h0, 1'b1);
    idle();
    idle();
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 3'd0, 4'(i + 2), 1'b0);
    cyc(1'b1, 1'b0, 3'd0, 4'hF, 1'b1);
    idle();
    idle();
    check("commit_slot7_frame", live(), 32'h2345678F);

    // 5: backpressure during COPY, then acceptance into next slot
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 3'd0, 4'h1, 1'b0);
    cyc(1'b1, 1'b0, 3'd0, 4'h5, 1'b0);
    cyc(1'b1, 1'b0, 3'd0, 4'h3, 1'b0);
    check("bp_not_written_ptr", wr_ptr, 0);
    cyc(1'b1, 1'b0, 3'd0, 4'h3, 1'b0);
    check("bp_accepted_ptr", wr_ptr, 1);
    cyc(1'b0, 1'b0, 3'd0, 4'h0, 1'b1);
    idle();
    check("bp_frame", live(), 32'h31111115);

    // 6: mid-frame reset, then full frame 1..8
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 3'd0, 4'hC, 1'b0);
    do_reset(1);
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 3'd0, 4'(i + 1), 1'b0);
    idle();
    check("post_reset_frame", live(), 32'h12345678);
    idle();
    check("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
